row_compositor: RTL and testbench
=================================

Name: row_compositor

Overview:
- Parametrised successor to the fixed 4-row output selection in the display top.
- Sits between the screen driver, the text engine and N row sources (text or graphic).
- Routes per-row character codes to the text engine and per-row pixel bytes to the screen.
- Adds latency-aligned pixel selection, frame-boundary detection and tear-free vertical row scrolling.

Parameters:
- NUM_ROWS, 4, number of display rows; power of 2, range 2..8.
- PIXEL_ADDR_W, 10, width of the screen byte address (128x64 SSD1306 = 1024 bytes).
- COL_W, 4, width of the per-row character column index.
- GFX_ROW_MASK, 4'b1000, bit i=1 makes logical row i a graphic row (pixel bytes from gfx_in); 0 makes it a text row.
- PIPE_DEPTH, 1, cycles between pixel_address and arrival of text_pixel/gfx_in data; range 0..4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pixel_address  in  PIXEL_ADDR_W  byte address currently requested by the screen driver
- char_address  in  ROW_W+COL_W  text engine character address; ROW_W=log2(NUM_ROWS); upper ROW_W bits = physical row
- char_in  in  NUM_ROWS*8  flat bus of character codes; logical row i at bits [8i+7:8i]
- gfx_in  in  NUM_ROWS*8  flat bus of graphic pixel bytes, logical row i at [8i+7:8i]; aligned with text_pixel
- text_pixel  in  8  pixel byte from text engine
- scroll_req  in  1  single-cycle request to change scroll offset
- scroll_amt  in  ROW_W  requested new scroll offset
- char_out  out  8  character code to text engine
- pixel_out  out  8  pixel byte to screen driver
- frame_start  out  1  one-cycle pulse at each frame boundary
- scroll_busy  out  1  high while a scroll request is pending
- scroll_offset  out  ROW_W  currently applied offset

Behaviour:
- Reset (rst_n low, async): char_out=0, pixel_out=0, frame_start=0, scroll_busy=0, scroll_offset=0, pending amount=0, address pipeline cleared to 0.
- Row mapping: physical row p shows logical row L=(p+scroll_offset) mod NUM_ROWS; the sum wraps naturally in ROW_W bits.
- Physical pixel row = pixel_address[PIXEL_ADDR_W-1 -: ROW_W].
- char_out is registered, 1-cycle latency from char_address.
  - If L is a text row: char_out = char_in[L].
  - If L is a graphic row: char_out = 8'h00.
- Pixel path: the physical pixel row passes through a PIPE_DEPTH-stage delay line.
  - The delayed row, mapped through the offset, selects gfx_in[L] (graphic) or text_pixel (text).
  - pixel_out is registered. Total latency from pixel_address = PIPE_DEPTH+1.
- Frame boundary: detected when pixel_address==0 and the previous-cycle pixel_address!=0.
  - frame_start pulses high for exactly 1 cycle, registered (the cycle after detection).
  - The first frame after reset counts as a boundary: reset previous value is treated as nonzero.
- Scroll handshake, states IDLE and PENDING:
  - IDLE + scroll_req: latch scroll_amt, go to PENDING, scroll_busy=1 next cycle.
  - PENDING + frame boundary: scroll_offset <= latched amount, go to IDLE, scroll_busy=0 next cycle.
  - PENDING + new scroll_req: latched amount overwritten; stay PENDING (last request wins).
  - scroll_req in the same cycle as a boundary while IDLE: latched, not applied; takes effect at the next boundary.
  - scroll_req coinciding with a boundary while PENDING: the old amount is applied and the new amount is latched; remain PENDING.
- scroll_offset never changes mid-frame. Delayed pixel rows in flight across a boundary use the offset in force when they exit the delay line.
- Reset mid-frame or mid-pending: pending request discarded, offset returns to 0.

Optional Feature:
- Macro ROW_INVERT_EN.
- Defined: extra input row_invert [NUM_ROWS-1:0], indexed by physical row. pixel_out is XORed with 8'hFF for rows whose bit is set, using the delayed physical row; no added latency.
- Undefined: port absent, no inversion.

Test Plan:
- Reset then pixel_address sweeps 0..1023 with GFX_ROW_MASK=4'b1000 and gfx_in row3=8'hAA:
  - frame_start pulses once, the cycle after address 0 is detected;
  - pixel_out=text_pixel for addresses 0..767 and 8'hAA for 768..1023, each 2 cycles after its address (PIPE_DEPTH=1).
- char_in={8'h44,8'h43,8'h42,8'h41}, char_address row bits 0..3 -> char_out 8'h41, 8'h42, 8'h43, then 8'h00 (graphic row 3), each 1 cycle later.
- scroll_req with scroll_amt=1 at address 300:
  - scroll_busy=1 until the next frame boundary; scroll_offset=1 after it;
  - char_address row 0 -> 8'h42, row 2 -> 8'h00; pixel rows 512..767 -> gfx 8'hAA.
- Two scroll_req pulses (amt=2, then amt=3) in one frame -> scroll_offset=3 at the boundary; 2 is never applied.
- Assert rst_n low while PENDING at address 900 -> all outputs 0 immediately; no offset change at the next boundary.
- ROW_INVERT_EN defined, row_invert=4'b0001, text_pixel=8'h0F -> pixel_out=8'hF0 for addresses 0..255 and 8'h0F for 256..767.

Source files
------------

// File: rtl/row_compositor.sv
// Row compositor: maps physical display rows to logical text/graphic sources with
// latency-aligned pixel select, frame detection and tear-free scrolling. Optional: ROW_INVERT_EN.
module row_compositor #(
  parameter int                  NUM_ROWS     = 4,
  parameter int                  PIXEL_ADDR_W = 10,
  parameter int                  COL_W        = 4,
  parameter logic [NUM_ROWS-1:0] GFX_ROW_MASK = 4'b1000,
  parameter int                  PIPE_DEPTH   = 1,
  localparam int                 ROW_W        = $clog2(NUM_ROWS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PIXEL_ADDR_W-1:0] pixel_address,
  input  logic [ROW_W+COL_W-1:0]  char_address,
  input  logic [NUM_ROWS*8-1:0]   char_in,
  input  logic [NUM_ROWS*8-1:0]   gfx_in,
  input  logic [7:0]              text_pixel,
  input  logic                    scroll_req,
  input  logic [ROW_W-1:0]        scroll_amt,
`ifdef ROW_INVERT_EN
  input  logic [NUM_ROWS-1:0]     row_invert,
`endif
  output logic [7:0]              char_out,
  output logic [7:0]              pixel_out,
  output logic                    frame_start,
  output logic                    scroll_busy,
  output logic [ROW_W-1:0]        scroll_offset
);

  typedef enum logic {S_IDLE, S_PEND} state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] off_q, off_d;
  logic [ROW_W-1:0] amt_q, amt_d;
  logic             prev_nz_q, prev_nz_d;
  logic             fs_q, fs_d;
  logic [7:0]       char_q, char_d;
  logic [7:0]       pix_q, pix_d;

  logic             boundary, latch_en, apply_en;
  logic [ROW_W-1:0] prow, drow, crow, cl, pl;
  logic             unused_col;

  assign unused_col = ^char_address[COL_W-1:0];
  assign prow       = pixel_address[PIXEL_ADDR_W-1 -: ROW_W];
  assign crow       = char_address[ROW_W+COL_W-1 -: ROW_W];

  // Previous address reset-treated as nonzero so the first frame counts as a boundary.
  assign boundary  = (pixel_address == '0) && prev_nz_q;
  assign prev_nz_d = |pixel_address;
  assign fs_d      = boundary;

  // Row delay line aligning the physical row with text_pixel/gfx_in arrival.
  generate
    if (PIPE_DEPTH == 0) begin : g_nopipe
      assign drow = prow;
    end else begin : g_pipe
      logic [PIPE_DEPTH-1:0][ROW_W-1:0] row_pipe_q, row_pipe_d;
      always_comb begin
        row_pipe_d[0] = prow;
        for (int i = 1; i < PIPE_DEPTH; i++) row_pipe_d[i] = row_pipe_q[i-1];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) row_pipe_q <= '0;
        else        row_pipe_q <= row_pipe_d;
      end
      assign drow = row_pipe_q[PIPE_DEPTH-1];
    end
  endgenerate

  // Scroll FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Scroll FSM: next state. A request on the applying boundary keeps us pending.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (scroll_req) state_d = S_PEND;
      S_PEND:  if (boundary && !scroll_req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Scroll FSM: outputs. Latching always captures the newest request.
  always_comb begin
    latch_en    = scroll_req;
    apply_en    = (state_q == S_PEND) && boundary;
    scroll_busy = (state_q == S_PEND);
  end

  always_comb begin
    amt_d = latch_en ? scroll_amt : amt_q;
    off_d = apply_en ? amt_q : off_q;
  end

  always_comb begin
    cl     = ROW_W'(crow + off_q);
    char_d = GFX_ROW_MASK[cl] ? 8'h00 : char_in[{cl, 3'b000} +: 8];
  end

  // Rows leaving the delay line use whatever offset is in force at that moment.
  always_comb begin
    pl    = ROW_W'(drow + off_q);
    pix_d = GFX_ROW_MASK[pl] ? gfx_in[{pl, 3'b000} +: 8] : text_pixel;
`ifdef ROW_INVERT_EN
    if (row_invert[drow]) pix_d = pix_d ^ 8'hFF;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q     <= '0;
      amt_q     <= '0;
      prev_nz_q <= 1'b1;
      fs_q      <= 1'b0;
      char_q    <= 8'h00;
      pix_q     <= 8'h00;
    end else begin
      off_q     <= off_d;
      amt_q     <= amt_d;
      prev_nz_q <= prev_nz_d;
      fs_q      <= fs_d;
      char_q    <= char_d;
      pix_q     <= pix_d;
    end
  end

  assign char_out      = char_q;
  assign pixel_out     = pix_q;
  assign frame_start   = fs_q;
  assign scroll_offset = off_q;

endmodule

// File: tb/tb_row_compositor.sv
// Randomized bench for row_compositor (default parameters) against a cycle-level reference model.
module tb_row_compositor;
  localparam logic [3:0] GFX = 4'b1000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [9:0]  pixel_address = '0;
  logic [5:0]  char_address = '0;
  logic [31:0] char_in = '0, gfx_in = '0;
  logic [7:0]  text_pixel = '0;
  logic        scroll_req = 1'b0;
  logic [1:0]  scroll_amt = '0;
`ifdef ROW_INVERT_EN
  logic [3:0]  row_invert = '0;
`endif
  logic [7:0]  char_out, pixel_out;
  logic        frame_start, scroll_busy;
  logic [1:0]  scroll_offset;

  row_compositor dut (
    .clk(clk), .rst_n(rst_n), .pixel_address(pixel_address), .char_address(char_address),
    .char_in(char_in), .gfx_in(gfx_in), .text_pixel(text_pixel),
    .scroll_req(scroll_req), .scroll_amt(scroll_amt),
`ifdef ROW_INVERT_EN
    .row_invert(row_invert),
`endif
    .char_out(char_out), .pixel_out(pixel_out), .frame_start(frame_start),
    .scroll_busy(scroll_busy), .scroll_offset(scroll_offset));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  // Reference model: offset in force, last pending amount, and the physical row
  // whose pixel data arrives one cycle after its address.
  logic [1:0] m_off, m_amt, m_prev_row;
  logic       m_pend, m_prev_nz;
  logic [7:0] e_char, e_pix;
  logic       e_fs, e_busy;
  logic [1:0] e_off;

  task automatic model_reset();
    m_off = 0; m_amt = 0; m_pend = 0; m_prev_nz = 1; m_prev_row = 0;
  endtask

  function automatic logic [7:0] src_byte(input logic [31:0] bus, input logic [1:0] r);
    return bus[8*r +: 8];
  endfunction

  task automatic drive(input logic [9:0] a, input logic req, input logic [1:0] amt);
    logic [31:0] r;
    logic [1:0]  lc, lp;
    logic        bnd;
    r = $urandom;
    pixel_address = a; scroll_req = req; scroll_amt = amt;
    char_address = r[5:0]; text_pixel = r[15:8];
    char_in = $urandom; gfx_in = $urandom;
`ifdef ROW_INVERT_EN
    row_invert = r[19:16];
`endif
    bnd = (a == 0) && m_prev_nz;
    lc = 2'(char_address[5:4] + m_off);
    e_char = GFX[lc] ? 8'h00 : src_byte(char_in, lc);
    lp = 2'(m_prev_row + m_off);
    e_pix = GFX[lp] ? src_byte(gfx_in, lp) : text_pixel;
`ifdef ROW_INVERT_EN
    if (row_invert[m_prev_row]) e_pix = ~e_pix;
`endif
    e_fs = bnd;
    if (m_pend && bnd) begin
      m_off = m_amt;
      if (req) m_amt = amt; else m_pend = 0;
    end else if (req) begin
      m_amt = amt; m_pend = 1;
    end
    e_busy = m_pend; e_off = m_off;
    m_prev_nz = (a != 0); m_prev_row = a[9:8];
  endtask

  task automatic check_outs();
    chk("char_out", char_out, e_char);
    chk("pixel_out", pixel_out, e_pix);
    chk("frame_start", frame_start, e_fs);
    chk("scroll_busy", scroll_busy, e_busy);
    chk("scroll_offset", scroll_offset, e_off);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_char"}, char_out, 0);
    chk({tag, "_pix"}, pixel_out, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_busy"}, scroll_busy, 0);
    chk({tag, "_off"}, scroll_offset, 0);
  endtask

  initial begin
    logic [9:0] a;
    logic       req;
    logic [1:0] amt;
    int         f;
    bit         rst_done;
    a = 0; f = 0; rst_done = 0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 9000; c++) begin
      if (c != 0) begin
        if (f >= 3 && $urandom_range(0, 49) == 0) a = 10'($urandom_range(0, 1023));
        else if (a == 0 && f >= 3 && $urandom_range(0, 3) == 0) a = 0;
        else begin
          if (a == 10'd1023) f++;
          a = 10'(a + 1);
        end
      end
      req = 0; amt = 2'($urandom);
      if (f == 1 && a == 300) begin req = 1; amt = 1; end
      if (f == 2 && a == 100) begin req = 1; amt = 2; end
      if (f == 2 && a == 500) begin req = 1; amt = 3; end
      if (f >= 3 && (a == 0 || $urandom_range(0, 299) == 0)) req = 1;
      drive(a, req, amt);
      @(negedge clk);
      check_outs();
      if (!rst_done && f == 2 && a == 900 && m_pend) begin
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rst_done = 1;
      end
    end
    chk("mid_reset_hit", {31'd0, rst_done}, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
